// File: rtl/playback_controller.sv
// Ping-pong playback scheduler. The loader fills buffer[active_buffer] while
// playback drains buffer[~active_buffer]. Block length and hold count come from
// the variable RAM; data-RAM words are streamed gaplessly to pattern_out.
module playback_controller #(
  parameter int DATA_W = 32,
  parameter int BLK_AW = 11,
  parameter int VAR_AW = 4,
  parameter int HOLD_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              load_complete,
  output logic              active_buffer,
  output logic [VAR_AW-1:0] vaddr,
  input  logic [DATA_W-1:0] vdata,
  output logic [BLK_AW:0]   daddr,
  input  logic [DATA_W-1:0] ddata,
  output logic [DATA_W-1:0] pattern_out,
  output logic              pattern_valid,
  output logic              busy,
  output logic              underrun,
  output logic              overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_VARS, S_WAIT, S_PLAY, S_GAP1, S_GAP2
  } state_t;

  localparam logic [BLK_AW-1:0] WORD_ONE = {{(BLK_AW-1){1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [VAR_AW-1:0] VADDR_ONE = {{(VAR_AW-1){1'b0}}, 1'b1};

  state_t              state_r, fsm_n_s, state_n_s;
  logic [1:0]          vcnt_r;
  logic [BLK_AW-1:0]   wcount_r, word_r;
  logic [HOLD_W-1:0]   hold_r, hcnt_r;
  logic [1:0]          buf_full_r, buf_full_n_s;
  logic                active_buffer_r, play_buf_s;
  logic [VAR_AW-1:0]   vaddr_r;
  logic [BLK_AW:0]     daddr_r;
  logic [DATA_W-1:0]   pattern_out_r;
  logic                pattern_valid_r, fetch_valid_r, busy_r;
  logic                underrun_r, overrun_r;
  logic                start_c_s, blk_start_c_s, underrun_c_s;
  logic                start_s, blk_start_s, underrun_set_s, overrun_set_s;
  logic                last_word_s, hold_done_s, clear_s, swap_s;

  assign play_buf_s  = ~active_buffer_r;
  assign last_word_s = (word_r == wcount_r);
  assign hold_done_s = (hcnt_r == hold_r);
  // The playback buffer is released as soon as its final address goes out.
  assign clear_s = (state_r == S_PLAY) && last_word_s &&
                   (hcnt_r == {HOLD_W{1'b0}}) && !stop;
  assign swap_s  = !stop && buf_full_r[active_buffer_r] && !buf_full_r[play_buf_s];

  // Next-state logic; stop overrides every transition and strobe.
  always_comb begin
    fsm_n_s       = state_r;
    start_c_s     = 1'b0;
    blk_start_c_s = 1'b0;
    underrun_c_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          fsm_n_s   = S_VARS;
          start_c_s = 1'b1;
        end else begin
          fsm_n_s = S_IDLE;
        end
      end
      S_VARS: begin
        if (vcnt_r == 2'd2) fsm_n_s = S_WAIT;
        else                fsm_n_s = S_VARS;
      end
      S_WAIT: begin
        if (buf_full_r[play_buf_s]) begin
          fsm_n_s       = S_PLAY;
          blk_start_c_s = 1'b1;
        end else begin
          fsm_n_s = S_WAIT;
        end
      end
      S_PLAY: begin
        if (last_word_s && hold_done_s) fsm_n_s = S_GAP1;
        else                            fsm_n_s = S_PLAY;
      end
      S_GAP1: fsm_n_s = S_GAP2;
      S_GAP2: begin
        if (buf_full_r[play_buf_s]) begin
          fsm_n_s       = S_PLAY;
          blk_start_c_s = 1'b1;
        end else begin
          fsm_n_s      = S_WAIT;
          underrun_c_s = 1'b1;
        end
      end
      default: fsm_n_s = S_IDLE;
    endcase
    state_n_s      = stop ? S_IDLE : fsm_n_s;
    start_s        = start_c_s && !stop;
    blk_start_s    = blk_start_c_s && !stop;
    underrun_set_s = underrun_c_s && !stop;
  end

  // Buffer-full bookkeeping: loader sets, playback clears, stop wipes both.
  always_comb begin
    buf_full_n_s  = buf_full_r;
    overrun_set_s = 1'b0;
    if (stop) begin
      buf_full_n_s = 2'b00;
    end else begin
      if (load_complete) begin
        if (buf_full_r[active_buffer_r]) overrun_set_s = 1'b1;
        else                             buf_full_n_s[active_buffer_r] = 1'b1;
      end else begin
        overrun_set_s = 1'b0;
      end
      buf_full_n_s[play_buf_s] = clear_s ? 1'b0 : buf_full_n_s[play_buf_s];
    end
  end

  // State, ownership and sticky status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= S_IDLE;
      busy_r          <= 1'b0;
      buf_full_r      <= 2'b00;
      active_buffer_r <= 1'b1;
      underrun_r      <= 1'b0;
      overrun_r       <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      busy_r     <= (state_n_s != S_IDLE);
      buf_full_r <= buf_full_n_s;
      if (swap_s) active_buffer_r <= play_buf_s;
      if (underrun_set_s)  underrun_r <= 1'b1;
      else if (start_s)    underrun_r <= 1'b0;
      if (overrun_set_s)   overrun_r <= 1'b1;
      else if (start_s)    overrun_r <= 1'b0;
    end
  end

  // Variable fetch: address 0 then 1, each word latched one cycle after issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      vcnt_r   <= 2'd0;
      vaddr_r  <= {VAR_AW{1'b0}};
      wcount_r <= {BLK_AW{1'b0}};
      hold_r   <= {HOLD_W{1'b0}};
    end else if (start_s) begin
      vcnt_r  <= 2'd0;
      vaddr_r <= {VAR_AW{1'b0}};
    end else if (state_r == S_VARS) begin
      vcnt_r <= vcnt_r + 2'd1;
      if (vcnt_r == 2'd0) vaddr_r  <= VADDR_ONE;
      if (vcnt_r == 2'd1) wcount_r <= vdata[BLK_AW-1:0];
      if (vcnt_r == 2'd2) hold_r   <= vdata[HOLD_W-1:0];
    end
  end

  // Address sequencer: each word address stays on daddr for HOLD+1 cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_r  <= {BLK_AW{1'b0}};
      hcnt_r  <= {HOLD_W{1'b0}};
      daddr_r <= {(BLK_AW+1){1'b0}};
    end else if (blk_start_s) begin
      word_r  <= {BLK_AW{1'b0}};
      hcnt_r  <= {HOLD_W{1'b0}};
      daddr_r <= {play_buf_s, {BLK_AW{1'b0}}};
    end else if ((state_r == S_PLAY) && !stop) begin
      if (hold_done_s) begin
        hcnt_r <= {HOLD_W{1'b0}};
        if (last_word_s) begin
          word_r <= {BLK_AW{1'b0}};
        end else begin
          word_r  <= word_r + WORD_ONE;
          daddr_r <= {play_buf_s, word_r + WORD_ONE};
        end
      end else begin
        hcnt_r <= hcnt_r + HOLD_ONE;
      end
    end
  end

  // Output pipeline tracking the data RAM's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_valid_r   <= 1'b0;
      pattern_valid_r <= 1'b0;
      pattern_out_r   <= {DATA_W{1'b0}};
    end else begin
      fetch_valid_r   <= (state_r == S_PLAY) && !stop;
      pattern_valid_r <= fetch_valid_r && !stop;
      if (fetch_valid_r && !stop) pattern_out_r <= ddata;
    end
  end

  assign active_buffer = active_buffer_r;
  assign vaddr         = vaddr_r;
  assign daddr         = daddr_r;
  assign pattern_out   = pattern_out_r;
  assign pattern_valid = pattern_valid_r;
  assign busy          = busy_r;
  assign underrun      = underrun_r;
  assign overrun       = overrun_r;

endmodule

// File: tb/tb_playback_controller.sv
// Bench for playback_controller: RAM models, a block-schedule reference model,
// directed scenarios with literal pins, then randomized control traffic.
module tb_playback_controller;

  logic        clk = 1'b0;
  logic        reset, start, stop, load_complete;
  logic        active_buffer, pattern_valid, busy, underrun, overrun;
  logic [3:0]  vaddr;
  logic [11:0] daddr;
  logic [31:0] vdata, ddata, pattern_out;
  logic [31:0] vmem [0:15];
  logic [31:0] dmem [0:4095];

  int n_checks = 0;
  int n_err    = 0;
  int now      = 0;

  // Model state: values expected during the cycle after the latest step.
  int          m_phase;   // 0 idle, 1 vars, 2 wait, 3 play, 4 gap
  int          m_vcnt, m_wc, m_hold, m_blk_t, m_pb, m_gap_end, m_daddr;
  logic        m_blk_on, m_ab, m_under, m_over, m_pv, m_dchk;
  logic [1:0]  m_full;
  logic [31:0] m_po;

  always #5 clk = ~clk;

  playback_controller dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .load_complete(load_complete), .active_buffer(active_buffer),
    .vaddr(vaddr), .vdata(vdata), .daddr(daddr), .ddata(ddata),
    .pattern_out(pattern_out), .pattern_valid(pattern_valid),
    .busy(busy), .underrun(underrun), .overrun(overrun)
  );

  // Registered-read RAMs.
  always @(posedge clk) begin
    vdata <= vmem[vaddr];
    ddata <= dmem[daddr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, now);
    end
  endtask

  // Advance the model by one cycle using the inputs about to be sampled.
  task automatic model_step();
    int L, k, c, j;
    logic [1:0] nf;
    logic nab, start_ok;
    int nph;
    if (reset) begin
      m_phase = 0; m_ab = 1'b1; m_full = 2'b00; m_under = 1'b0; m_over = 1'b0;
      m_po = 32'd0; m_pv = 1'b0; m_blk_on = 1'b0; m_dchk = 1'b1; m_daddr = 0;
    end else begin
      L = (m_wc + 1) * (m_hold + 1);
      k = now - m_blk_t;
      nf = m_full; nab = m_ab; nph = m_phase;
      start_ok = (m_phase == 0) && start && !stop;
      if (stop) begin
        nf = 2'b00; nph = 0; m_blk_on = 1'b0;
      end else begin
        if (start_ok) begin m_under = 1'b0; m_over = 1'b0; end
        if (load_complete) begin
          if (m_full[m_ab]) m_over = 1'b1;
          else nf[m_ab] = 1'b1;
        end
        if (m_phase == 3 && k == m_wc * (m_hold + 1)) nf[m_pb] = 1'b0;
        if (m_full[m_ab] && !m_full[!m_ab]) nab = !m_ab;
        case (m_phase)
          0: if (start_ok) begin nph = 1; m_vcnt = 0; end
          1: begin
            if (m_vcnt == 1) m_wc = int'(vmem[0][10:0]);
            else if (m_vcnt == 2) begin m_hold = int'(vmem[1][15:0]); nph = 2; end
            m_vcnt++;
          end
          2: if (m_full[!m_ab]) begin
            m_blk_t = now + 1; m_pb = int'(!m_ab); m_blk_on = 1'b1; nph = 3;
          end
          3: if (k == L - 1) begin nph = 4; m_gap_end = now + 2; end
          4: if (now == m_gap_end) begin
            if (m_full[!m_ab]) begin
              m_blk_t = now + 1; m_pb = int'(!m_ab); m_blk_on = 1'b1; nph = 3;
            end else begin
              m_under = 1'b1; nph = 2;
            end
          end
          default: nph = 0;
        endcase
      end
      c = now + 1;
      L = (m_wc + 1) * (m_hold + 1);
      j = c - m_blk_t;
      if (m_blk_on && j >= 2 && j <= L + 1) begin
        m_pv = 1'b1;
        m_po = dmem[m_pb * 2048 + (j - 2) / (m_hold + 1)];
      end else begin
        m_pv = 1'b0;
      end
      m_dchk = (nph == 3);
      if (m_dchk) m_daddr = m_pb * 2048 + j / (m_hold + 1);
      m_full = nf; m_ab = nab; m_phase = nph;
    end
    now++;
  endtask

  task automatic compare_all();
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("active_buffer", 32'(active_buffer), 32'(m_ab));
    chk("underrun", 32'(underrun), 32'(m_under));
    chk("overrun", 32'(overrun), 32'(m_over));
    chk("pattern_valid", 32'(pattern_valid), 32'(m_pv));
    chk("pattern_out", pattern_out, m_po);
    if (m_dchk) chk("daddr", 32'(daddr), 32'(m_daddr));
  endtask

  task automatic tick(input logic rs, input logic st, input logic sp, input logic ld);
    reset = rs; start = st; stop = sp; load_complete = ld;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic        pv_rec [0:39];
  logic        ur_rec [0:39];
  logic [31:0] po_rec [0:39];
  logic [11:0] da_rec [0:39];

  initial begin
    int i0;
    int guard;
    reset = 1'b1; start = 1'b0; stop = 1'b0; load_complete = 1'b0;
    for (int i = 0; i < 16; i++) vmem[i] = 32'd0;
    for (int i = 0; i < 4096; i++) dmem[i] = 32'hDEAD_0000 + 32'(i);
    for (int i = 0; i < 8; i++) begin
      dmem[2048 + i] = 32'h1000_0000 + 32'(i);
      dmem[i]        = 32'h2000_0000 + 32'(i);
    end
    vmem[0] = 32'hABCD_F003;   // WCOUNT = 3 after masking
    vmem[1] = 32'h5A5A_0000;   // HOLD = 0

    // Reset values
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_active_buffer", 32'(active_buffer), 32'd1);
    chk("rst_vaddr", 32'(vaddr), 32'd0);
    chk("rst_daddr", 32'(daddr), 32'd0);
    chk("rst_pattern_out", pattern_out, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", 32'({underrun, overrun, pattern_valid}), 32'd0);

    // Scenario: WCOUNT=3, HOLD=0, gapless words, 2-cycle latency
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    chk("t1_swap_ab", 32'(active_buffer), 32'd0);
    chk("t1_pre_valid", 32'(pattern_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("t1_valid", 32'(pattern_valid), 32'd1);
      chk("t1_word", pattern_out, 32'h1000_0000 + 32'(i));
    end
    idle(1);
    chk("t1_end_valid", 32'(pattern_valid), 32'd0);

    // No second load: underrun, output holds last word, late load resumes
    idle(4);
    chk("t4_underrun", 32'(underrun), 32'd1);
    chk("t4_hold_last", pattern_out, 32'h1000_0003);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    guard = 0;
    while (!pattern_valid && guard < 12) begin idle(1); guard++; end
    chk("t4_resume_valid", 32'(pattern_valid), 32'd1);
    chk("t4_resume_word", pattern_out, 32'h2000_0000);
    idle(1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6_stop_busy", 32'(busy), 32'd0);
    chk("t6_stop_valid", 32'(pattern_valid), 32'd0);

    // HOLD=2, WCOUNT=1 with a mid-block load of the other buffer
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    vmem[0] = 32'h0000_0001;
    vmem[1] = 32'hFFFF_0002;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 40; r++) begin
      tick(1'b0, 1'b0, 1'b0, (r == 2));
      pv_rec[r] = pattern_valid; po_rec[r] = pattern_out;
      da_rec[r] = daddr; ur_rec[r] = underrun;
    end
    i0 = -1;
    for (int i = 0; i < 40; i++) if (i0 < 0 && pv_rec[i]) i0 = i;
    chk("t2_first_valid_idx", 32'(i0), 32'd3);
    if (i0 >= 2 && i0 <= 20) begin
      chk("t2_daddr0", 32'(da_rec[i0 - 2]), 32'h800);
      chk("t2_daddr1", 32'(da_rec[i0 + 1]), 32'h801);
      for (int i = 0; i < 3; i++) begin
        chk("t2_w0", po_rec[i0 + i], 32'h1000_0000);
        chk("t2_w0_valid", 32'(pv_rec[i0 + i]), 32'd1);
        chk("t2_w1", po_rec[i0 + 3 + i], 32'h1000_0001);
        chk("t3_b0w0", po_rec[i0 + 8 + i], 32'h2000_0000);
        chk("t3_b0w1", po_rec[i0 + 11 + i], 32'h2000_0001);
      end
      chk("t3_gap", 32'({pv_rec[i0 + 6], pv_rec[i0 + 7]}), 32'd0);
      chk("t3_after_gap", 32'(pv_rec[i0 + 8]), 32'd1);
      chk("t3_no_underrun", 32'(ur_rec[i0 + 13]), 32'd0);
    end

    // Overrun: three back-to-back loads without a drain
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_start_clears_underrun", 32'(underrun), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_overrun", 32'(overrun), 32'd1);

    // Reset mid-block
    idle(9);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_rst_ab", 32'(active_buffer), 32'd1);
    chk("t6_rst_flags", 32'({underrun, overrun, busy, pattern_valid}), 32'd0);
    chk("t6_rst_po", pattern_out, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4096; i++) dmem[i] = $urandom;
    for (int n = 0; n < 4000; n++) begin
      if (m_phase == 0 && ($urandom % 16) == 0) begin
        vmem[0] = ($urandom & 32'hFFFF_F800) | 32'($urandom_range(0, 5));
        vmem[1] = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
        idle(1);
      end else begin
        tick(($urandom % 500) == 0, ($urandom % 12) == 0,
             ($urandom % 90) == 0, ($urandom % 9) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
